cmp_share_arbiter: RTL and testbench

- Shares one instance of the team's N-bit magnitude comparator (greater/equal/less outputs) among REQ requesters.
- Round-robin arbitration selects one requester; its operand pair is registered into the comparator and the registered result is returned with the winner's ID over a valid/ready response channel.
- Sits between the datapath clients and the comparator as its sole sequencer.
- Exactly one comparison is in flight at a time.

---
 rtl/cmp_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter
//   Sequences one shared unsigned N-bit magnitude comparator among REQ
//   requesters. An arbiter in IDLE picks one pending requester, its operand
//   pair is registered (CMP), the registered greater/equal/less result is
//   then presented with the winner's index on a valid/ready response channel
//   (RESP). Exactly one comparison is in flight at a time; grant-to-response
//   latency is 2 cycles and the minimum issue interval is 3 cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  [REQ]    requester i has an operand pair pending
//   req_a      [REQ*N]  A operands, requester i at [i*N +: N]
//   req_b      [REQ*N]  B operands, same packing
//   req_ready  [REQ]    one-hot grant pulse (combinational, IDLE only)
//   rsp_valid           result valid
//   rsp_ready           consumer accepts the result
//   rsp_id     [IDW]    requester index owning the result
//   rsp_g/e/l           A>B / A==B / A<B (unsigned)
//   busy                high in CMP and RESP
//
// Build option
//   CMP_SHARE_FIXED_PRIO_EN: when defined, the lowest set req_valid index
//   always wins and no round-robin pointer exists. Default is round-robin.

module cmp_share_arbiter #(
  parameter int N   = 16,
  parameter int REQ = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ-1:0]   req_valid,
  input  logic [REQ*N-1:0] req_a,
  input  logic [REQ*N-1:0] req_b,
  output logic [REQ-1:0]   req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic             rsp_g,
  output logic             rsp_e,
  output logic             rsp_l,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t         state;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic [N-1:0]   a_p0;
  logic [N-1:0]   b_p0;
  logic [IDW-1:0] id_p0;
`ifndef CMP_SHARE_FIXED_PRIO_EN
  logic [IDW-1:0] rr_ptr;
`endif

  // Ripple magnitude compare from the MSB down, seeded at "equal"; the first
  // differing bit decides and later bits are ignored. Result is {g, e, l}.
  function automatic logic [2:0] mag_cmp(input logic [N-1:0] a, input logic [N-1:0] b);
    logic g;
    logic e;
    logic l;
    g = 1'b0;
    e = 1'b1;
    l = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (e) begin
        if (a[i] && !b[i]) begin
          g = 1'b1;
          e = 1'b0;
        end else if (!a[i] && b[i]) begin
          l = 1'b1;
          e = 1'b0;
        end
      end
    end
    return {g, e, l};
  endfunction

  // Arbitration: choose the pending requester with the smallest distance
  // above the round-robin pointer (or the lowest index in the fixed build).
  always_comb begin
    int best;
    int d;
    gnt_any = 1'b0;
    gnt_idx = '0;
    best    = REQ;
    d       = 0;
    for (int i = 0; i < REQ; i++) begin
      if (req_valid[i]) begin
`ifdef CMP_SHARE_FIXED_PRIO_EN
        d = i;
`else
        d = i - int'(rr_ptr);
        if (d < 0) d = d + REQ;
`endif
        if (d < best) begin
          best    = d;
          gnt_any = 1'b1;
          gnt_idx = IDW'(i);
        end
      end
    end
  end

  // Grant pulse and operand mux for the winner. The pulse is suppressed
  // while rst is high so nothing is reported as taken during reset.
  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int k = 0; k < REQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        sel_a = req_a[k*N +: N];
        sel_b = req_b[k*N +: N];
        req_ready[k] = gnt_any && (state == IDLE) && !rst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
`ifndef CMP_SHARE_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
      a_p0      <= '0;
      b_p0      <= '0;
      id_p0     <= '0;
      rsp_id    <= '0;
      rsp_g     <= 1'b0;
      rsp_e     <= 1'b1;
      rsp_l     <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        // IDLE -> CMP: capture the granted operand pair (stage p0)
        IDLE: begin
          if (gnt_any) begin
            a_p0  <= sel_a;
            b_p0  <= sel_b;
            id_p0 <= gnt_idx;
            busy  <= 1'b1;
            state <= CMP;
`ifndef CMP_SHARE_FIXED_PRIO_EN
            rr_ptr <= (gnt_idx == IDW'(REQ-1)) ? '0 : gnt_idx + IDW'(1);
`endif
          end
        end
        // CMP -> RESP: register the comparator result with its owner
        CMP: begin
          {rsp_g, rsp_e, rsp_l} <= mag_cmp(a_p0, b_p0);
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        // RESP: hold until the consumer takes it; no grant in this cycle
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
module tb_cmp_share_arbiter;
  localparam int N   = 16;
  localparam int REQ = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REQ-1:0]   req_valid = '0;
  logic [REQ*N-1:0] req_a = '0;
  logic [REQ*N-1:0] req_b = '0;
  logic             rsp_ready = 1'b1;
  logic [REQ-1:0]   req_ready;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic             rsp_g;
  logic             rsp_e;
  logic             rsp_l;
  logic             busy;

  cmp_share_arbiter #(.N(N), .REQ(REQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_g(rsp_g), .rsp_e(rsp_e), .rsp_l(rsp_l), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a grant starts a transaction at cycle g_cyc; its result
  // becomes visible at g_cyc+2 and stays until accepted; no new grant while a
  // transaction is outstanding.
  int             cyc = 0;
  int             g_cyc = 0;
  int             m_ptr = 0;
  bit             inflight = 0;
  bit             model_ok = 0;
  logic [IDW-1:0] pend_id = '0;
  logic [2:0]     pend_gel = 3'b010;
  logic [IDW-1:0] out_id = '0;
  logic [2:0]     out_gel = 3'b010;

  function automatic int pick(input logic [REQ-1:0] v, input int ptr);
    for (int k = 0; k < REQ; k++) begin
      int i;
      i = (ptr + k) % REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] ref_cmp(input logic [N-1:0] a, input logic [N-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc = 0; inflight = 0; m_ptr = 0;
        out_id = '0; out_gel = 3'b010; model_ok = 1;
      end else begin
        if (inflight && cyc >= g_cyc + 2 && rsp_ready) begin
          inflight = 0;
        end else if (!inflight && req_valid != '0) begin
          int p;
          p = pick(req_valid, m_ptr);
          pend_id  = IDW'(p);
          pend_gel = ref_cmp(req_a[p*N +: N], req_b[p*N +: N]);
          g_cyc    = cyc;
          inflight = 1;
`ifndef CMP_SHARE_FIXED_PRIO_EN
          m_ptr = (p + 1) % REQ;
`endif
        end
        cyc++;
        if (inflight && cyc == g_cyc + 2) begin
          out_id  = pend_id;
          out_gel = pend_gel;
        end
      end
    end
  end

  function automatic logic [REQ-1:0] exp_ready();
    logic [REQ-1:0] r;
    r = '0;
    if (!rst && !inflight && req_valid != '0) r[pick(req_valid, m_ptr)] = 1'b1;
    return r;
  endfunction

  // Compare process: every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && model_ok) begin
        check("m_req_ready", 32'(req_ready), 32'(exp_ready()));
        check("m_rsp_valid", 32'(rsp_valid), 32'(inflight && cyc >= g_cyc + 2));
        check("m_busy", 32'(busy), 32'(inflight));
        check("m_rsp_id", 32'(rsp_id), 32'(out_id));
        check("m_rsp_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'(out_gel));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
    req_valid[i]      = v;
    req_a[i*N +: N]   = a;
    req_b[i*N +: N]   = b;
  endtask

  task automatic one_req(input string nm, input int i, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [2:0] exp_gel);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_req(i, 1'b1, a, b);
    @(negedge clk);
    check({nm, "_ready"}, 32'(req_ready), 32'(1) << i);
    check({nm, "_busy0"}, 32'(busy), 32'(0));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    check({nm, "_cmp_busy"}, 32'(busy), 32'(1));
    check({nm, "_cmp_vld"}, 32'(rsp_valid), 32'(0));
    @(negedge clk);
    check({nm, "_vld"}, 32'(rsp_valid), 32'(1));
    check({nm, "_id"}, 32'(rsp_id), 32'(i));
    check({nm, "_gel"}, 32'({rsp_g, rsp_e, rsp_l}), 32'(exp_gel));
    @(negedge clk);
    check({nm, "_done_busy"}, 32'(busy), 32'(0));
    check({nm, "_done_vld"}, 32'(rsp_valid), 32'(0));
  endtask

  task automatic new_ops(input int i);
    logic [N-1:0] a;
    logic [N-1:0] b;
    a = N'($urandom);
    case ($urandom_range(0, 3))
      0: b = N'($urandom);
      1: b = a;
      2: begin a = {N{1'b1}}; b = '0; end
      default: b = a + N'($urandom_range(0, 2)) - N'(1);
    endcase
    set_req(i, 1'b1, a, b);
  endtask

  initial begin
    int g_ord[5];
    int g_at[5];
    int ng;
    logic [IDW-1:0] snap_id;
    logic [2:0]     snap_gel;
    logic [REQ-1:0] gseen;

    // Reset values with requests pending: no grant may show during reset
    req_valid = '1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_valid", 32'(rsp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_id", 32'(rsp_id), 32'(0));
    check("rst_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'(3'b010));
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    one_req("basic", 1, 16'h1234, 16'h1233, 3'b100);
    one_req("ones_eq", 2, 16'hFFFF, 16'hFFFF, 3'b010);
    one_req("zero_lt", 3, 16'h0000, 16'hFFFF, 3'b001);
    one_req("msb_gt", 0, 16'h8000, 16'h7FFF, 3'b100);
    one_req("zeros_eq", 1, 16'h0000, 16'h0000, 3'b010);
    one_req("max_gt", 2, 16'hFFFF, 16'h0000, 3'b100);

    // Back-pressure: response held, requester 2 waits
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 16'h0005, 16'h0009);
    @(negedge clk);
    check("bp_grant0", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(2, 1'b1, 16'h0007, 16'h0007);
    @(negedge clk);
    @(negedge clk);
    snap_id = rsp_id;
    snap_gel = {rsp_g, rsp_e, rsp_l};
    check("bp_gel", 32'(snap_gel), 32'(3'b001));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_no_grant", 32'(req_ready), 32'(0));
      check("bp_hold_vld", 32'(rsp_valid), 32'(1));
      check("bp_hold_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'(snap_gel));
      check("bp_hold_id", 32'(rsp_id), 32'(snap_id));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_last_resp", 32'(rsp_valid), 32'(1));
    @(negedge clk);
    check("bp_grant2", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_r2_id", 32'(rsp_id), 32'(2));
    check("bp_r2_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'(3'b010));
    @(negedge clk);

    // Reset during CMP aborts the comparison
    @(posedge clk); #1;
    set_req(3, 1'b1, 16'hFFFF, 16'h0001);
    @(negedge clk);
    check("ab_grant3", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); #1;
    req_valid = '1;
    rst = 1'b1;
    #1;
    check("ab_busy", 32'(busy), 32'(0));
    check("ab_vld", 32'(rsp_valid), 32'(0));
    check("ab_ready", 32'(req_ready), 32'(0));
    check("ab_gel", 32'({rsp_g, rsp_e, rsp_l}), 32'(3'b010));
    check("ab_id", 32'(rsp_id), 32'(0));
    repeat (3) begin
      @(negedge clk);
      check("ab_no_rsp", 32'(rsp_valid), 32'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // All four held: record five grants
    ng = 0;
    for (int c = 0; c < 30 && ng < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < REQ; i++) if (req_ready[i]) g_ord[ng] = i;
        g_at[ng] = c;
        ng++;
      end
    end
    check("rr_grants_seen", 32'(ng), 32'(5));
    for (int k = 0; k < 5 && k < ng; k++) begin
`ifdef CMP_SHARE_FIXED_PRIO_EN
      check("fp_order", 32'(g_ord[k]), 32'(0));
`else
      check("rr_order", 32'(g_ord[k]), 32'(k % REQ));
`endif
      if (k > 0) check("rr_interval", 32'(g_at[k] - g_at[k-1]), 32'(3));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gseen = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < REQ; i++) begin
        if (req_valid[i] && gseen[i]) begin
          if ($urandom_range(0, 1) == 1) new_ops(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 99) < 30) new_ops(i);
        end else if ($urandom_range(0, 99) < 3) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
